// File: rtl/des_key_sched_iter.sv
// ------------------------------------------------------------------------------
// des_key_sched_iter / p_box_56_48 : iterative DES key schedule (PC-1, C/D rotate, PC-2). Rev 1.0
// ------------------------------------------------------------------------------
`default_nettype none

module p_box_56_48 (
  input  logic [55:0] in_i,
  output logic [47:0] out_o
);
  // PC-2 in DES bit numbering (1 = MSB of the 56-bit C/D word)
  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign out_o[47-i] = in_i[56-PC2_TBL[i]];
  end

  logic unused_bits;
  assign unused_bits = ^{in_i[47], in_i[38], in_i[34], in_i[31],
                         in_i[21], in_i[18], in_i[13], in_i[2]};
endmodule

module des_key_sched_iter #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  input  logic [63:0] key_i,
  input  logic        decrypt_i,
  output logic        rk_valid_o,
  input  logic        rk_ready_i,
  output logic [47:0] round_key_o,
  output logic [3:0]  round_idx_o,
  output logic        last_o,
  output logic        busy_o
);
  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t      state_q;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  idx_q;
  logic        dec_q;
  logic [55:0] pc1;
  logic [3:0]  idx_fwd, idx_bwd;

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1[55-i] = key_i[64-PC1_TBL[i]];
  end

  logic unused_parity;
  assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                           key_i[24], key_i[16], key_i[8],  key_i[0]};

  function automatic logic single_shift(input logic [3:0] r);
    return (r == 4'd0) || (r == 4'd1) || (r == 4'd8) || (r == 4'd15);
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  // Decrypt walks the encrypt rotation schedule backwards from C16D16 = C0D0
  always_comb begin
    idx_fwd = idx_q + 4'd1;
    idx_bwd = LAST_IDX - idx_q;
    if (dec_q) begin
      cd_d = {rotr28(cd_q[55:28], single_shift(idx_bwd)),
              rotr28(cd_q[27:0],  single_shift(idx_bwd))};
    end else begin
      cd_d = {rotl28(cd_q[55:28], single_shift(idx_fwd)),
              rotl28(cd_q[27:0],  single_shift(idx_fwd))};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cd_q    <= '0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (key_valid_i) begin
            cd_q    <= decrypt_i ? pc1
                                 : {rotl28(pc1[55:28], 1'b1), rotl28(pc1[27:0], 1'b1)};
            idx_q   <= '0;
            dec_q   <= decrypt_i;
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (rk_ready_i) begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_IDLE;
            end else begin
              idx_q <= idx_fwd;
              cd_q  <= cd_d;
            end
          end
        end
      endcase
    end
  end

  p_box_56_48 u_pc2 (
    .in_i  (cd_q),
    .out_o (round_key_o)
  );

  assign key_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q == S_EMIT);
  assign rk_valid_o  = (state_q == S_EMIT);
  assign round_idx_o = idx_q;
  assign last_o      = (state_q == S_EMIT) && (idx_q == LAST_IDX);

endmodule

`default_nettype wire

// File: tb/tb_des_key_sched_iter.sv
// ------------------------------------------------------------------------------
// tb_des_key_sched_iter : self-checking bench with a cumulative-shift DES key model. Rev 1.0
// ------------------------------------------------------------------------------
`default_nettype none

module tb_des_key_sched_iter;
  logic        clk = 1'b0;
  logic        rst, key_valid_i, decrypt_i, rk_ready_i;
  logic [63:0] key_i;
  logic        key_ready_o, rk_valid_o, last_o, busy_o;
  logic [47:0] round_key_o;
  logic [3:0]  round_idx_o;

  always #5 clk = ~clk;

  des_key_sched_iter #(.NUM_ROUNDS(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid_i (key_valid_i),
    .key_ready_o (key_ready_o),
    .key_i       (key_i),
    .decrypt_i   (decrypt_i),
    .rk_valid_o  (rk_valid_o),
    .rk_ready_i  (rk_ready_i),
    .round_key_o (round_key_o),
    .round_idx_o (round_idx_o),
    .last_o      (last_o),
    .busy_o      (busy_o)
  );

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] K2  = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Round key Kn straight from the textbook: total left shift after n rounds, then PC-2
  function automatic logic [47:0] model_rk(input logic [63:0] key, input int n);
    logic [55:0] p, cd;
    logic [27:0] c, d;
    logic [47:0] k;
    int sh;
    for (int i = 0; i < 56; i++) p[55-i] = key[64-PC1[i]];
    c  = p[55:28];
    d  = p[27:0];
    sh = 0;
    for (int r = 1; r <= n; r++) sh += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
    for (int s = 0; s < sh; s++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2[i]];
    return k;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level view of the schedule: which key, which direction, which beat
  bit          m_busy = 1'b0;
  bit          m_dec  = 1'b0;
  int          m_idx  = 0;
  logic [63:0] m_key  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_idx  = 0;
    end else if (!m_busy) begin
      if (key_valid_i) begin
        m_busy = 1'b1;
        m_idx  = 0;
        m_dec  = decrypt_i;
        m_key  = key_i;
      end
    end else if (rk_ready_i) begin
      if (m_idx == 15) m_busy = 1'b0;
      else             m_idx++;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("key_ready", key_ready_o, !m_busy);
      chk("rk_valid",  rk_valid_o,  m_busy);
      chk("busy",      busy_o,      m_busy);
      chk("last",      last_o,      m_busy && (m_idx == 15));
      chk("round_idx", round_idx_o, m_idx);
      if (m_busy)
        chk("round_key", round_key_o,
            m_dec ? model_rk(m_key, 16 - m_idx) : model_rk(m_key, m_idx + 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [63:0] k, input logic d);
    key_valid_i = 1'b1;
    key_i       = k;
    decrypt_i   = d;
    rk_ready_i  = 1'b1;
    tick();
    key_valid_i = 1'b0;
  endtask

  // Entered just after a clock edge; counts handshakes until the block is idle again
  task automatic drain(output int beats);
    bit done;
    beats = 0;
    done  = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (key_ready_o) done = 1'b1;
      else begin
        if (rk_valid_o && rk_ready_i) beats++;
        tick();
      end
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          beats;
    logic [47:0] held;

    rst = 1'b1; key_valid_i = 1'b0; decrypt_i = 1'b0; rk_ready_i = 1'b0; key_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_key_ready", key_ready_o, 1'b1);
    chk("rst_rk_valid",  rk_valid_o,  1'b0);
    chk("rst_last",      last_o,      1'b0);
    chk("rst_busy",      busy_o,      1'b0);
    chk("rst_idx",       round_idx_o, 4'd0);
    chk("rst_key",       round_key_o, 48'h0);
    chk_en = 1'b1;

    chk("model_k1",  model_rk(KEY, 1),  K1);
    chk("model_k2",  model_rk(KEY, 2),  K2);
    chk("model_k16", model_rk(KEY, 16), K16);

    // Encrypt vector
    start(KEY, 1'b0);
    @(negedge clk); chk("enc_beat0", round_key_o, K1);
    tick();
    @(negedge clk); chk("enc_beat1", round_key_o, K2);
    repeat (14) tick();
    @(negedge clk);
    chk("enc_beat15", round_key_o, K16);
    chk("enc_last",   last_o, 1'b1);
    tick();
    @(negedge clk); chk("enc_ready_after", key_ready_o, 1'b1);

    // Decrypt vector
    start(KEY, 1'b1);
    @(negedge clk); chk("dec_beat0", round_key_o, K16);
    repeat (14) tick();
    @(negedge clk); chk("dec_beat14", round_key_o, K2);
    tick();
    @(negedge clk);
    chk("dec_beat15", round_key_o, K1);
    chk("dec_last",   last_o, 1'b1);
    tick();

    // Backpressure at beat 3
    start(64'h0E329232EA6D0D73, 1'b0);
    repeat (3) tick();
    rk_ready_i = 1'b0;
    @(negedge clk); held = round_key_o;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("bp_key_stable", round_key_o, held);
      chk("bp_idx_stable", round_idx_o, 4'd3);
    end
    tick();
    rk_ready_i = 1'b1;
    drain(beats);
    chk("bp_total_beats", 3 + beats, 16);

    // New key offered while busy at beat 7
    start(KEY, 1'b0);
    repeat (7) tick();
    @(negedge clk); chk("busy_not_ready", key_ready_o, 1'b0);
    key_valid_i = 1'b1; key_i = 64'hFEDCBA9876543210; decrypt_i = 1'b1;
    tick();
    key_valid_i = 1'b0;
    drain(beats);
    chk("busy_remaining_beats", beats, 8);

    // Reset at beat 9
    start(KEY, 1'b0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", key_ready_o, 1'b1);
    chk("midrst_valid", rk_valid_o,  1'b0);
    chk("midrst_idx",   round_idx_o, 4'd0);
    start(KEY, 1'b0);
    @(negedge clk); chk("midrst_fresh_k1", round_key_o, K1);
    drain(beats);
    chk("midrst_fresh_beats", beats, 15);

    // Back-to-back encrypt then decrypt, key_valid held high throughout
    key_valid_i = 1'b1; key_i = KEY; decrypt_i = 1'b0; rk_ready_i = 1'b1;
    tick();
    decrypt_i = 1'b1;
    repeat (15) tick();
    @(negedge clk);
    chk("b2b_first_last", last_o, 1'b1);
    tick();
    @(negedge clk); chk("b2b_ready_gap", key_ready_o, 1'b1);
    tick();
    key_valid_i = 1'b0;
    @(negedge clk);
    chk("b2b_second_k16", round_key_o, K16);
    chk("b2b_second_idx", round_idx_o, 4'd0);
    repeat (15) tick();
    @(negedge clk); chk("b2b_second_last", last_o, 1'b1);
    tick();
    @(negedge clk); chk("b2b_done_34", key_ready_o, 1'b1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      key_valid_i = ($urandom_range(0, 3) == 0);
      key_i       = {$urandom, $urandom};
      decrypt_i   = 1'($urandom_range(0, 1));
      rk_ready_i  = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0; key_valid_i = 1'b0; rk_ready_i = 1'b1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/des_key_sched_iter.md
Name: des_key_sched_iter

Overview:
- Iterative DES key schedule. Sits upstream of the Feistel round datapath and takes the place of the unrolled per-round key-generator chain.
- Accepts one 64-bit key through a valid/ready handshake and applies PC-1 to it.
- Streams the 16 48-bit round keys, one per handshake beat, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Holds one 56-bit C/D register, rotates it per round, and produces each round key through the existing p_box_56_48 (PC-2) instance.

Parameters:
- NUM_ROUNDS, 16, number of round keys emitted per key. Fixed at 16 for DES; any other value is unsupported.

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- key_valid_i  input  1  key_i/decrypt_i are valid this cycle
- key_ready_o  output  1  block can accept a new key (IDLE)
- key_i  input  64  DES key; DES bit 1 = key_i[63]; parity bits (8,16,..,64) ignored
- decrypt_i  input  1  1 = emit K16..K1; 0 = emit K1..K16; sampled at key accept
- rk_valid_o  output  1  round_key_o valid
- rk_ready_i  input  1  downstream consumes round key this cycle
- round_key_o  output  48  current round key, PC-2 of the C/D register
- round_idx_o  output  4  beat index 0..15 of the current round key
- last_o  output  1  high with rk_valid_o when round_idx_o==15
- busy_o  output  1  inverse of key_ready_o

Behaviour:
- Reset: state=IDLE, cd_q=0, idx_q=0, dec_q=0. key_ready_o=1, rk_valid_o=0, last_o=0, busy_o=0, round_idx_o=0. round_key_o=PC2(0)=0.
- rst has priority over every other event and aborts an in-flight schedule immediately. No further round keys are emitted.
- States: IDLE, EMIT.
  - key_ready_o = (state==IDLE).
  - rk_valid_o = (state==EMIT).
- Rotation amounts per beat index r:
  - s(r) = 1 for r in {0,1,8,15}; otherwise s(r) = 2.
  - C = cd[55:28] and D = cd[27:0] rotate independently. Rotations never cross the C/D boundary.
- Accept (IDLE, key_valid_i=1):
  - pc1 = PC-1(key_i), 56 bits.
  - If decrypt_i=0: cd_q <= rotl(pc1, 1). If decrypt_i=1: cd_q <= pc1, unrotated, because the total rotation of 28 returns the register to C0D0, which gives K16.
  - Also: idx_q <= 0, dec_q <= decrypt_i, state <= EMIT.
- Latency: the first round key is valid the cycle after the key is accepted.
- EMIT beat (rk_valid_o & rk_ready_i):
  - If idx_q==15: state <= IDLE. cd_q and idx_q hold.
  - Else idx_q <= idx_q+1.
    - Encrypt: cd_q <= rotl(cd_q, s(idx_q+1)).
    - Decrypt: cd_q <= rotr(cd_q, s(15-idx_q)). This yields the decrypt rotation sequence 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Backpressure: while rk_valid_o=1 and rk_ready_i=0, round_key_o, round_idx_o and last_o hold stable.
- key_valid_i is ignored in EMIT; key_ready_o=0 then. A new key can be accepted the cycle after the last beat.
- Minimum throughput: 17 cycles per key, i.e. 1 accept cycle plus 16 beats.
- round_idx_o = idx_q and is independent of direction. The decrypt key at index j is K(16-j).
- The datapath is purely registered C/D followed by combinational PC-2. There are no other pipeline registers.

Test Plan:
- Encrypt vector: key_i=64'h133457799BBCDFF1, decrypt_i=0, rk_ready_i=1 -> beat0=48'h1B02EFFC7072, beat1=48'h79AED9DBC9E5, beat15=48'hCB3D8B0E17F5 with last_o=1. key_ready_o returns to 1 the cycle after.
- Decrypt vector: same key, decrypt_i=1 -> beat0=48'hCB3D8B0E17F5, beat14=48'h79AED9DBC9E5, beat15=48'h1B02EFFC7072. All 16 beats equal the encrypt beats in reverse order.
- Backpressure: hold rk_ready_i=0 for 5 cycles at beat 3 -> round_key_o and round_idx_o=3 stable throughout. Exactly 16 beats total, no skip or duplicate.
- Busy rejection: pulse key_valid_i with a different key during beat 7 -> ignored; key_ready_o=0; remaining keys still match the original key.
- Reset mid-operation: assert rst at beat 9 for 1 cycle -> next cycle key_ready_o=1, rk_valid_o=0, round_idx_o=0. A fresh encrypt then yields 48'h1B02EFFC7072 first.
- Back-to-back: encrypt then decrypt keys offered continuously -> second accept occurs exactly the cycle after the first last_o handshake. Total 34 cycles with rk_ready_i=1.
